fft_bitrev_reorder: RTL and testbench

//  Output reorder stage placed directly downstream of FFT (radix-2^2 SDF).
//  The SDF pipeline emits bins in bit-reversed order. This block restores

---
 rtl/fft_bitrev_reorder.sv | 118 +++++++++++
 tb/tb_fft_bitrev_reorder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Restores natural bin order after a radix-2^2 SDF FFT using a two-bank ping-pong buffer.
// Latency: 2 cycles from the last input sample of a frame to bin 0; no backpressure, one sample per clock.
module fft_bitrev_reorder #(
  parameter int N     = 256,
  parameter int WIDTH = 8,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic {IDLE, READ} rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Bank select is the MSB of the RAM address.
  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] ram_dat_q;

  logic             frame_done;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_vld_q, rd_vld_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic             enable_out_q, enable_out_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;
  logic [LOG2N-1:0] out_index_q, out_index_d;
  logic             out_last_q, out_last_d;

  always_ff @(posedge clk) begin
    if (enable_in) mem[{wr_bank_q, bitrev(wr_cnt_q)}] <= {in_re, in_im};
    if (rd_state_q == READ) ram_dat_q <= mem[{rd_bank_q, rd_cnt_q}];
  end

  always_comb begin
    frame_done = enable_in && (wr_cnt_q == LAST_IDX);
    wr_cnt_d   = enable_in ? wr_cnt_q + LOG2N'(1) : wr_cnt_q;
    wr_bank_d  = frame_done ? ~wr_bank_q : wr_bank_q;

    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    if (rd_state_q == READ) begin
      rd_cnt_d = rd_cnt_q + LOG2N'(1);
      if (rd_cnt_q == LAST_IDX) rd_state_d = IDLE;
    end
    // A completing frame wins over the end of the current read, so output has no gap.
    if (frame_done) begin
      rd_state_d = READ;
      rd_cnt_d   = '0;
      rd_bank_d  = wr_bank_q;
    end

    rd_vld_d     = (rd_state_q == READ);
    rd_idx_d     = rd_cnt_q;

    enable_out_d = rd_vld_q;
    out_re_d     = rd_vld_q ? ram_dat_q[2*WIDTH-1:WIDTH] : '0;
    out_im_d     = rd_vld_q ? ram_dat_q[WIDTH-1:0] : '0;
    out_index_d  = rd_vld_q ? rd_idx_q : '0;
    out_last_d   = rd_vld_q && (rd_idx_q == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_state_q   <= IDLE;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_idx_q     <= '0;
      enable_out_q <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_state_q   <= rd_state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_bank_q    <= rd_bank_d;
      rd_vld_q     <= rd_vld_d;
      rd_idx_q     <= rd_idx_d;
      enable_out_q <= enable_out_d;
      out_re_q     <= out_re_d;
      out_im_q     <= out_im_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
    end
  end

  assign enable_out = enable_out_q;
  assign out_re     = out_re_q;
  assign out_im     = out_im_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: ramp, latency, gaps, back-to-back frames, resets.
module tb_fft_bitrev_reorder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_in;
  logic [7:0] in_re, in_im;
  logic       enable_out;
  logic [7:0] out_re, out_im, out_index;
  logic       out_last;

  fft_bitrev_reorder #(.N(256), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .in_re(in_re), .in_im(in_im),
    .enable_out(enable_out), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] re;
    logic [7:0] im;
    logic [7:0] idx;
    logic       last;
  } cap_t;

  typedef struct {
    int         j;
    logic [7:0] re;
    logic [7:0] im;
  } vec_t;

  cap_t cap[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   idle_bad = 0;
  int   t_last   = 0;

  always @(posedge clk) cyc++;

  // Sample away from the active edge; also police idle outputs.
  always @(negedge clk) begin
    if (enable_out) begin
      cap.push_back('{cyc: cyc, re: out_re, im: out_im, idx: out_index, last: out_last});
    end else if (out_re != 0 || out_im != 0 || out_index != 0 || out_last != 0) begin
      idle_bad++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] br8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Drives arrival samples k=0..n-1 with re=k^seed, im=~k; leaves enable_in high at the end.
  task automatic feed(input int seed, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      enable_in = 1'b1;
      in_re     = 8'(k) ^ 8'(seed);
      in_im     = ~8'(k);
      if (gaps && (k % 16 == 15) && k != n - 1) begin
        int r = $urandom_range(1, 5);
        for (int g = 0; g < r; g++) begin
          @(negedge clk);
          enable_in = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1 t_last = cyc;
  endtask

  task automatic stop_input();
    @(negedge clk);
    enable_in = 1'b0;
  endtask

  task automatic wait_cap(input string name, input int n, input int budget);
    for (int i = 0; i < budget && cap.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk({name, " capture count reached"}, int'(cap.size() >= n), 1);
  endtask

  task automatic check_frame(input string name, input int off, input int seed);
    int bad = 0;
    if (cap.size() < off + 256) begin
      chk({name, " frame present"}, cap.size(), off + 256);
    end else begin
      for (int j = 0; j < 256; j++) begin
        cap_t c = cap[off + j];
        logic [7:0] jj = 8'(j);
        if (c.idx != jj || c.re != (br8(jj) ^ 8'(seed)) || c.im != ~br8(jj) ||
            c.last != (j == 255) || c.cyc != cap[off].cyc + j) bad++;
      end
      chk({name, " frame sample errors"}, bad, 0);
    end
  endtask

  initial begin
    vecs[0] = '{j: 0,   re: 8'd0,   im: 8'd255};
    vecs[1] = '{j: 1,   re: 8'd128, im: 8'd127};
    vecs[2] = '{j: 2,   re: 8'd64,  im: 8'd191};
    vecs[3] = '{j: 3,   re: 8'd192, im: 8'd63};
    vecs[4] = '{j: 4,   re: 8'd32,  im: 8'd223};
    vecs[5] = '{j: 17,  re: 8'd136, im: 8'd119};
    vecs[6] = '{j: 100, re: 8'd38,  im: 8'd217};
    vecs[7] = '{j: 128, re: 8'd1,   im: 8'd254};
    vecs[8] = '{j: 255, re: 8'd255, im: 8'd0};

    rst_n = 1'b0; enable_in = 1'b0; in_re = '0; in_im = '0;
    #3;
    chk("reset enable_out", int'(enable_out), 0);
    chk("reset out_re", int'(out_re), 0);
    chk("reset out_im", int'(out_im), 0);
    chk("reset out_index", int'(out_index), 0);
    chk("reset out_last", int'(out_last), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1 / T2: ramp frame and latency
    feed(0, 256, 1'b0);
    stop_input();
    wait_cap("T1", 256, 400);
    if (cap.size() >= 256) begin
      chk("T2 first valid cycle", cap[0].cyc, t_last + 2);
      chk("T2 first index", int'(cap[0].idx), 0);
      chk("T2 last flag cycle", cap[255].cyc, t_last + 257);
      chk("T2 out_last at 255", int'(cap[255].last), 1);
      foreach (vecs[v]) begin
        chk($sformatf("T1 re j=%0d", vecs[v].j), int'(cap[vecs[v].j].re), int'(vecs[v].re));
        chk($sformatf("T1 im j=%0d", vecs[v].j), int'(cap[vecs[v].j].im), int'(vecs[v].im));
      end
    end
    check_frame("T1", 0, 0);
    repeat (5) @(negedge clk);
    #1 chk("T2 exactly N valid", cap.size(), 256);
    chk("T2 enable_out fell", int'(enable_out), 0);

    // T3: gapped input
    cap.delete();
    feed(0, 256, 1'b1);
    stop_input();
    wait_cap("T3", 256, 400);
    check_frame("T3", 0, 0);
    repeat (5) @(negedge clk);
    #1 chk("T3 exactly N valid", cap.size(), 256);

    // T4: four back-to-back frames
    cap.delete();
    for (int f = 0; f < 4; f++) feed(f + 1, 256, 1'b0);
    stop_input();
    wait_cap("T4", 1024, 400);
    for (int f = 0; f < 4; f++) check_frame($sformatf("T4 f%0d", f), 256 * f, f + 1);
    if (cap.size() >= 1024) chk("T4 contiguous span", cap[1023].cyc - cap[0].cyc, 1023);
    repeat (5) @(negedge clk);
    #1 chk("T4 exactly 4N valid", cap.size(), 1024);

    // T5: reset while reading at out_index=100
    cap.delete();
    feed(7, 256, 1'b0);
    stop_input();
    begin
      int i = 0;
      while (i < 400 && !(enable_out && out_index == 8'd100)) begin
        @(negedge clk);
        i++;
      end
      chk("T5 reached index 100", int'(enable_out && out_index == 8'd100), 1);
    end
    rst_n = 1'b0;
    #1;
    chk("T5 enable_out after reset", int'(enable_out), 0);
    chk("T5 out_re after reset", int'(out_re), 0);
    chk("T5 out_im after reset", int'(out_im), 0);
    chk("T5 out_index after reset", int'(out_index), 0);
    chk("T5 out_last after reset", int'(out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    repeat (20) @(negedge clk);
    #1 chk("T5 silent after reset", cap.size(), 0);
    feed(9, 256, 1'b0);
    stop_input();
    wait_cap("T5", 256, 400);
    check_frame("T5", 0, 9);
    repeat (5) @(negedge clk);
    #1 chk("T5 exactly N valid", cap.size(), 256);

    // T6: reset after a partial frame
    cap.delete();
    feed(11, 50, 1'b0);
    @(negedge clk);
    enable_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    feed(13, 256, 1'b0);
    stop_input();
    wait_cap("T6", 256, 400);
    chk("T6 first valid cycle", cap.size() > 0 ? cap[0].cyc : -1, t_last + 2);
    check_frame("T6", 0, 13);
    repeat (5) @(negedge clk);
    #1 chk("T6 exactly N valid", cap.size(), 256);

    chk("idle outputs zero", idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
